// File: rtl/rice_core_scoreboard_register_file.sv
// Register file with a per-register busy scoreboard, multi-port writeback and flush.
// Optional macro RICE_CORE_RF_BYPASS_EN forwards same-cycle writeback data to the read ports.
module rice_core_scoreboard_register_file #(
    parameter int XLEN        = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int RF_SIZE     = 32,
    localparam int ADDR_W     = $clog2(RF_SIZE)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]      i_rs_addr,
    output logic [READ_PORTS-1:0][XLEN-1:0]        o_rs_value,
    output logic [READ_PORTS-1:0]                  o_rs_busy,
    input  logic                                   i_alloc_valid,
    input  logic [ADDR_W-1:0]                      i_alloc_rd,
    input  logic [WRITE_PORTS-1:0]                 i_wb_valid,
    input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]     i_wb_rd,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]       i_wb_value,
    input  logic                                   i_flush,
    output logic [ADDR_W:0]                        o_busy_count
);

    logic [XLEN-1:0]    regs_q [RF_SIZE];
    logic [XLEN-1:0]    regs_d [RF_SIZE];
    logic [RF_SIZE-1:0] busy_q;
    logic [RF_SIZE-1:0] busy_d;
    logic [ADDR_W:0]    count_q;
    logic [ADDR_W:0]    count_d;

    // Ascending port order lets the highest-indexed writeback overwrite earlier ones.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < WRITE_PORTS; k++) begin
            if (i_wb_valid[k] && (i_wb_rd[k] != '0)) begin
                regs_d[i_wb_rd[k]] = i_wb_value[k];
                busy_d[i_wb_rd[k]] = 1'b0;
            end
        end
        if (i_flush) begin
            busy_d = '0;
        end else if (i_alloc_valid && (i_alloc_rd != '0)) begin
            busy_d[i_alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < RF_SIZE; i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    generate
        for (genvar gi = 0; gi < RF_SIZE; gi++) begin : g_reg
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign o_busy_count = count_q;

    generate
        for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read
            logic [XLEN-1:0] rd_value;
            logic            rd_busy;

            always_comb begin
                rd_value = (i_rs_addr[gi] == '0) ? '0 : regs_q[i_rs_addr[gi]];
                rd_busy  = busy_q[i_rs_addr[gi]];
`ifdef RICE_CORE_RF_BYPASS_EN
                // A forwarded value is fresh, so it is only busy if a new producer is issued now.
                if (!i_rst && (i_rs_addr[gi] != '0)) begin
                    for (int k = 0; k < WRITE_PORTS; k++) begin
                        if (i_wb_valid[k] && (i_wb_rd[k] == i_rs_addr[gi])) begin
                            rd_value = i_wb_value[k];
                            rd_busy  = i_alloc_valid && !i_flush && (i_alloc_rd == i_rs_addr[gi]);
                        end
                    end
                end
`endif
            end

            assign o_rs_value[gi] = rd_value;
            assign o_rs_busy[gi]  = rd_busy;
        end
    endgenerate

endmodule

// File: doc/rice_core_scoreboard_register_file.md
RICE_CORE_SCOREBOARD_REGISTER_FILE -- requirements
Module: rice_core_scoreboard_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of each register value.
REQ-002 SHALL have parameter READ_PORTS, default 2, number of independent read ports (1..4).
REQ-003 SHALL have parameter WRITE_PORTS, default 2, number of writeback ports (1..4).
REQ-004 SHALL have parameter RF_SIZE, default 32, number of architectural registers (power of two, 16 or 32); ADDR_W = log2(RF_SIZE).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: i_clk  input  1  clock, rising edge; i_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have i_rs_addr  input  READ_PORTS x ADDR_W  read register index per port.
REQ-007 SHALL have o_rs_value  output  READ_PORTS x XLEN  read data per port.
REQ-008 SHALL have o_rs_busy  output  READ_PORTS  scoreboard busy flag of the addressed register.
REQ-009 SHALL have i_alloc_valid  input  1, and i_alloc_rd  input  ADDR_W: an issued instruction will write this register.
REQ-010 SHALL have i_wb_valid  input  WRITE_PORTS, i_wb_rd  input  WRITE_PORTS x ADDR_W, and i_wb_value  input  WRITE_PORTS x XLEN: writeback ports.
REQ-011 SHALL have i_flush  input  1  pipeline flush; clears all pending allocations.
REQ-012 SHALL have o_busy_count  output  ADDR_W+1  number of registers whose busy bit is set.

Function
REQ-013 Register 0 SHALL always read 0 with busy 0; writes and allocations to index 0 are ignored.
REQ-014 Writes SHALL take effect on the rising edge when i_wb_valid[k]=1; the value is visible on the next cycle's reads (1-cycle write latency).
REQ-015 If multiple writeback ports target the same rd in one cycle, the highest-indexed port SHALL win, for both data and busy clearing.
REQ-016 Reads SHALL be combinational from the register array and busy vector (0-cycle latency).
REQ-017 The busy bit of rd SHALL be set at the edge where i_alloc_valid=1 and rd!=0.
REQ-018 The busy bit of rd SHALL be cleared at the edge where any i_wb_valid[k]=1 with i_wb_rd[k]=rd.
REQ-019 If alloc and writeback target the same rd in the same cycle, busy SHALL end set (the new producer wins), and the data SHALL still be written.
REQ-020 i_flush=1 SHALL clear all busy bits at the edge; any alloc in that cycle SHALL be dropped; writebacks in that cycle SHALL still update data.
REQ-021 o_busy_count SHALL be registered and always equal the population count of the busy vector; maximum RF_SIZE-1.
REQ-022 Writeback to a non-busy register SHALL update data and leave busy at 0 (no error).

Reset
REQ-023 While i_rst=1, all registers SHALL be 0, all busy bits 0, and o_busy_count 0, asynchronously.
REQ-024 o_rs_value SHALL read 0 and o_rs_busy 0 during reset; writes, allocs and flushes asserted during reset SHALL be ignored.
REQ-025 The first edge after i_rst deasserts SHALL process inputs normally.

Configuration
REQ-026 Macro RICE_CORE_RF_BYPASS_EN, when defined: a read of rd that matches a valid writeback in the same cycle SHALL return that writeback value (per REQ-015 priority), with o_rs_busy=0 unless an alloc to rd is also present; x0 excluded.
REQ-027 Without RICE_CORE_RF_BYPASS_EN, reads SHALL return only the stored array value and busy bit (REQ-016); same-cycle writeback is visible next cycle.

Verification
REQ-028 Reset, then read all ports at x0..x31 -> all values 0, busy 0, o_busy_count 0.
REQ-029 Alloc x5, next cycle read x5 -> busy 1, count 1; wb x5=0xDEADBEEF -> next cycle value 0xDEADBEEF, busy 0, count 0.
REQ-030 Same cycle wb port0 x7=0x11, port1 x7=0x22 -> x7 reads 0x22; also wb x0=0xFF -> x0 reads 0.
REQ-031 Alloc x3 together with wb x3=0x55 (x3 previously busy) -> value 0x55, busy stays 1, count unchanged.
REQ-032 Alloc x1, x2, x4; then flush with alloc x6 and wb x2=0x9 -> all busy 0, count 0, x2 reads 0x9.
REQ-033 With RICE_CORE_RF_BYPASS_EN, wb x9=0x1234 and read x9 same cycle -> o_rs_value 0x1234, busy 0; without it -> old value, 0x1234 next cycle.
